retire_trace_buffer: RTL and testbench

- Downstream consumer of the single-cycle RV32I core's retire/writeback interface (pc, instr, reg_write, reg_waddr, reg_wdata).
- Captures one commit record per retiring instruction into a FIFO and serializes each record as a fixed 13-byte little-endian packet on a valid/ready byte stream, for a UART or debug-link sink.
- Decouples the one-instruction-per-cycle core from a slow sink. On overflow it drops records, counts them, and flags the next accepted record.

---
 rtl/trace_pkg.sv | 42 ++++
 rtl/retire_trace_buffer_if.sv | 24 ++
 rtl/trace_fifo.sv | 52 +++++
 rtl/retire_trace_buffer.sv | 123 ++++++++++++
 tb/tb_retire_trace_buffer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace buffer: the commit record layout
// and the little-endian byte order used when a record is serialized onto the stream.
package trace_pkg;

  localparam int unsigned PKT_BYTES       = 13;
  localparam int unsigned FLAG_REG_WRITE  = 7;
  localparam int unsigned FLAG_OVERFLOW   = 6;
  localparam logic [7:0]  FLAG_WADDR_MASK = 8'h1F;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  flags;
    logic [31:0] wdata;
  } commit_rec_t;

  typedef enum logic {StIdle, StSend} ser_state_e;

  // Packet order: pc LE, instr LE, flags, wdata LE.
  function automatic logic [7:0] rec_byte(input commit_rec_t rec, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = rec.pc[7:0];
      4'd1:    b = rec.pc[15:8];
      4'd2:    b = rec.pc[23:16];
      4'd3:    b = rec.pc[31:24];
      4'd4:    b = rec.instr[7:0];
      4'd5:    b = rec.instr[15:8];
      4'd6:    b = rec.instr[23:16];
      4'd7:    b = rec.instr[31:24];
      4'd8:    b = rec.flags;
      4'd9:    b = rec.wdata[7:0];
      4'd10:   b = rec.wdata[15:8];
      4'd11:   b = rec.wdata[23:16];
      4'd12:   b = rec.wdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire-side capture signals and the outgoing valid/ready byte stream.
interface retire_trace_buffer_if;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic        retire_reg_write;
  logic [4:0]  retire_reg_waddr;
  logic [31:0] retire_reg_wdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output retire_valid, retire_pc, retire_instr, retire_reg_write, retire_reg_waddr,
           retire_reg_wdata, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, retire_reg_write, retire_reg_waddr,
           retire_reg_wdata, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of commit records; a push while full is accepted when a pop
// happens on the same edge, since the head slot is freed by that edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  commit_rec_t            i_data,
  output commit_rec_t            o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  commit_rec_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures one commit record per retired instruction and streams each as a 13-byte
// packet; overflowing records are dropped, counted, and flagged on the next accept.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  retire_trace_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic [DROP_W-1:0]      o_drop_count,
  output logic                   o_busy
);
  localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

  ser_state_e        r_state;
  commit_rec_t       r_rec;
  logic [3:0]        r_idx;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop;

  commit_rec_t w_rec;
  commit_rec_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_last_byte;
  logic        w_pop;
  logic        w_push_req;
  logic        w_accept;

  assign w_last_byte = (r_idx == LAST_IDX);
  assign w_pop       = !w_empty &&
                       ((r_state == StIdle) || (bus.out_ready && w_last_byte));
  assign w_push_req  = i_enable && bus.retire_valid;
  assign w_accept    = w_push_req && (!w_full || w_pop);

  always_comb begin
    w_rec                       = '0;
    w_rec.pc                    = bus.retire_pc;
    w_rec.instr                 = bus.retire_instr;
    w_rec.wdata                 = bus.retire_reg_wdata;
    w_rec.flags                 = 8'(bus.retire_reg_waddr) & FLAG_WADDR_MASK;
    w_rec.flags[FLAG_REG_WRITE] = bus.retire_reg_write;
    w_rec.flags[FLAG_OVERFLOW]  = r_ovf;
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_push_req) begin
      r_ovf <= 1'b1;
      if (r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rec       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_state     <= StSend;
            r_rec       <= w_head;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= rec_byte(w_head, 4'd0);
          end
        end
        StSend: begin
          if (bus.out_ready) begin
            if (w_last_byte) begin
              // Chain straight into the next packet when one is queued.
              if (w_pop) begin
                r_rec      <= w_head;
                r_idx      <= '0;
                r_out_data <= rec_byte(w_head, 4'd0);
              end else begin
                r_state     <= StIdle;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
              end
            end else begin
              r_idx      <= r_idx + 4'd1;
              r_out_data <= rec_byte(r_rec, r_idx + 4'd1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_drop_count  = r_drop;
  assign o_busy        = (r_state == StSend) || !w_empty;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: fixed packet vectors, directed corner
// sequences, and random traffic against a queue-based packet model.
module tb_retire_trace_buffer;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [3:0]        fc;
  logic [DROP_W-1:0] dc;
  logic              busy;

  retire_trace_buffer_if bus ();

  retire_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (en),
    .bus          (bus),
    .o_fifo_count (fc),
    .o_drop_count (dc),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  flags;
    logic [31:0] wd;
  } mrec_t;

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [103:0] pkt;
  } vec_t;

  mrec_t       m_fifo[$];
  logic [7:0]  m_pkt[$];
  int unsigned m_drop;
  bit          m_ovf;
  logic [7:0]  got[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          vcyc;
  bit          ended;
  bit          gap;
  bit          prev_stall;
  logic [7:0]  prev_data;
  vec_t        vt[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pkt.delete();
    m_drop = 0;
    m_ovf = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic model_push_pkt(input mrec_t r);
    for (int i = 0; i < 4; i++) m_pkt.push_back(8'(r.pc >> (8 * i)));
    for (int i = 0; i < 4; i++) m_pkt.push_back(8'(r.instr >> (8 * i)));
    m_pkt.push_back(r.flags);
    for (int i = 0; i < 4; i++) m_pkt.push_back(8'(r.wd >> (8 * i)));
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(m_pkt.size() != 0));
    if (m_pkt.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_pkt[0]));
    chk("fifo_count", 32'(fc), 32'(m_fifo.size()));
    chk("drop_count", 32'(dc), m_drop);
    chk("busy", 32'(busy), 32'(m_pkt.size() != 0 || m_fifo.size() != 0));
  endtask

  // Called just after a falling edge: drive inputs, advance the model over the
  // coming rising edge, then check outputs at the next falling edge.
  task automatic cycle(input logic e, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rdy);
    bit    hs, popf, acc;
    mrec_t r;
    if (prev_stall) chk("stall_hold", 32'(bus.out_data), 32'(prev_data));
    en = e;
    bus.retire_valid = v;
    bus.retire_pc = pc;
    bus.retire_instr = instr;
    bus.retire_reg_write = we;
    bus.retire_reg_waddr = wa;
    bus.retire_reg_wdata = wd;
    bus.out_ready = rdy;
    if (bus.out_valid) begin
      vcyc++;
      if (ended) gap = 1'b1;
    end else if (vcyc > 0) ended = 1'b1;
    if (bus.out_valid && rdy) got.push_back(bus.out_data);
    prev_stall = bus.out_valid && !rdy;
    prev_data = bus.out_data;
    hs   = (m_pkt.size() != 0) && rdy;
    popf = (m_fifo.size() != 0) && (m_pkt.size() == 0 || (hs && m_pkt.size() == 1));
    acc  = e && v && (m_fifo.size() < DEPTH || popf);
    r.pc = pc;
    r.instr = instr;
    r.wd = wd;
    r.flags = {we, m_ovf, 1'b0, wa};
    if (hs) void'(m_pkt.pop_front());
    if (popf) model_push_pkt(m_fifo.pop_front());
    if (acc) begin
      m_fifo.push_back(r);
      m_ovf = 1'b0;
    end else if (e && v) begin
      m_ovf = 1'b1;
      if (m_drop < (1 << DROP_W) - 1) m_drop++;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycle(input logic rdy);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 32'h0, rdy);
  endtask

  task automatic retire(input vec_t x, input logic rdy);
    cycle(1'b1, 1'b1, x.pc, x.instr, x.we, x.wa, x.wd, rdy);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((busy || bus.out_valid) && n < max_cycles) begin
      idle_cycle(1'b1);
      n++;
    end
    if (busy || bus.out_valid) chk("drain_timeout", 32'(busy), 32'h0);
  endtask

  task automatic clear_counts();
    got.delete();
    vcyc = 0;
    ended = 1'b0;
    gap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    bus.retire_valid = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_fifo_count", 32'(fc), 32'h0);
    chk("rst_drop_count", 32'(dc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_counts();
  endtask

  task automatic check_pkt(input string name, input int base, input logic [103:0] pkt);
    logic [103:0] p;
    p = pkt;
    for (int i = 0; i < 13; i++)
      if (base + i < got.size()) chk(name, 32'(got[base+i]), 32'(p[103-8*i -: 8]));
  endtask

  initial begin
    vec_t rv;
    int   n;
    vt[0] = '{32'h0, 32'h3E800093, 1'b1, 5'd1, 32'h3E8,
              104'h00000000_9300803E_81_E8030000};
    vt[1] = '{32'h1C, 32'h00602423, 1'b0, 5'd8, 32'h8,
              104'h1C000000_23246000_08_08000000};
    vt[2] = '{32'h80000004, 32'hFFF00513, 1'b1, 5'd10, 32'hFFFFFFFF,
              104'h04000080_1305F0FF_8A_FFFFFFFF};
    bus.retire_valid = 1'b0;
    bus.retire_pc = '0;
    bus.retire_instr = '0;
    bus.retire_reg_write = 1'b0;
    bus.retire_reg_waddr = '0;
    bus.retire_reg_wdata = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Single-packet vectors.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      retire(vt[k], 1'b1);
      drain(60);
      chk("pkt_len", got.size(), 32'd13);
      check_pkt("pkt_byte", 0, vt[k].pkt);
      chk("valid_cycles", vcyc, 32'd13);
      chk("busy_after", 32'(busy), 32'h0);
    end

    // Backpressure pattern 1,0,0 repeating.
    do_reset();
    retire(vt[0], 1'b1);
    n = 0;
    while (got.size() < 13 && n < 100) begin
      idle_cycle((n % 3) == 0);
      n++;
    end
    chk("bp_len", got.size(), 32'd13);
    check_pkt("bp_byte", 0, vt[0].pkt);
    drain(60);

    // Overflow: stalled sink, 12 retires.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rv = vt[i % 3];
      rv.pc = 32'h100 + 32'(4 * i);
      retire(rv, 1'b0);
    end
    chk("ovf_fifo_count", 32'(fc), 32'd8);
    chk("ovf_drop_count", 32'(dc), 32'd3);
    drain(400);
    clear_counts();
    retire(vt[0], 1'b1);
    retire(vt[2], 1'b1);
    drain(100);
    chk("ovf_len", got.size(), 32'd26);
    if (got.size() == 26) begin
      chk("ovf_flag_set", 32'(got[8][6]), 32'h1);
      chk("ovf_flag_clear", 32'(got[21][6]), 32'h0);
    end
    chk("ovf_drop_kept", 32'(dc), 32'd3);

    // Back-to-back packets.
    do_reset();
    for (int i = 0; i < 3; i++) retire(vt[i], 1'b1);
    drain(100);
    chk("b2b_len", got.size(), 32'd39);
    chk("b2b_valid_cycles", vcyc, 32'd39);
    chk("b2b_no_gap", 32'(gap), 32'h0);
    for (int i = 0; i < 3; i++) check_pkt("b2b_byte", 13 * i, vt[i].pkt);

    // Reset during byte 5 with a second record queued.
    do_reset();
    retire(vt[0], 1'b1);
    retire(vt[1], 1'b1);
    n = 0;
    while (got.size() < 5 && n < 50) begin
      idle_cycle(1'b1);
      n++;
    end
    chk("mid_reached_byte5", got.size(), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_fifo_count", 32'(fc), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    retire(vt[1], 1'b1);
    drain(60);
    chk("post_rst_len", got.size(), 32'd13);
    check_pkt("post_rst_byte", 0, vt[1].pkt);
    chk("post_rst_drop", 32'(dc), 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) < ((i < 300) ? 2 : 8));
    end
    drain(400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
